// File: rtl/pref_issue_queue_if.sv
// ---------------------------------------------------------------------------
// pref_issue_queue_if
// Purpose : groups the candidate, issue and statistics signals of the
//           prefetch issue queue into a single bundle.
// Signals :
//   pref_addrN_i / pref_validN_i  three candidate prefetch byte addresses
//   issue_valid_o / issue_addr_o  head block address offered to memory
//   issue_ready_i                 memory accepts the head (pop)
//   count_o                       queued entry count
//   drop_count_o / filter_count_o saturating loss / duplicate counters
// Modports: master = producer + memory side, slave = the queue itself.
// ---------------------------------------------------------------------------
interface pref_issue_queue_if #(
   parameter int QUEUE_DEPTH = 8
);
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   logic [63:0]   pref_addr1_i;
   logic [63:0]   pref_addr2_i;
   logic [63:0]   pref_addr3_i;
   logic          pref_valid1_i;
   logic          pref_valid2_i;
   logic          pref_valid3_i;
   logic          issue_valid_o;
   logic [63:0]   issue_addr_o;
   logic          issue_ready_i;
   logic [CW-1:0] count_o;
   logic [15:0]   drop_count_o;
   logic [15:0]   filter_count_o;

   modport master (
      output pref_addr1_i, pref_addr2_i, pref_addr3_i,
      output pref_valid1_i, pref_valid2_i, pref_valid3_i,
      output issue_ready_i,
      input  issue_valid_o, issue_addr_o, count_o, drop_count_o, filter_count_o
   );

   modport slave (
      input  pref_addr1_i, pref_addr2_i, pref_addr3_i,
      input  pref_valid1_i, pref_valid2_i, pref_valid3_i,
      input  issue_ready_i,
      output issue_valid_o, issue_addr_o, count_o, drop_count_o, filter_count_o
   );
endinterface

// File: rtl/pref_issue_queue.sv
// ---------------------------------------------------------------------------
// pref_issue_queue
// Purpose : FIFO of pending prefetch block addresses fed by up to three
//           candidates per cycle. Candidates already queued, recently issued
//           (filter ring) or enqueued earlier in the same cycle are dropped
//           as duplicates; candidates that find no free slot are dropped as
//           overflow. One head entry may be issued per cycle.
// Ports   :
//   clk  single clock, all state on posedge
//   rst  synchronous active-low reset
//   bus  pref_issue_queue_if.slave (candidates, issue handshake, counters)
// ---------------------------------------------------------------------------
module pref_issue_queue #(
   parameter int QUEUE_DEPTH  = 8,
   parameter int FILTER_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   pref_issue_queue_if.slave  bus
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;
   localparam int FW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
   localparam int BW = 58;   // block address width, bits [63:6]

   // Queue storage
   logic [BW-1:0]           r_q_blk [QUEUE_DEPTH];
   logic [QUEUE_DEPTH-1:0]  r_q_valid;
   logic [PW-1:0]           r_rd_ptr;
   logic [PW-1:0]           r_wr_ptr;
   logic [CW-1:0]           r_count;

   // Recently-issued filter ring
   logic [BW-1:0]           r_f_blk [FILTER_DEPTH];
   logic [FILTER_DEPTH-1:0] r_f_valid;
   logic [FW-1:0]           r_f_ptr;

   logic [15:0]             r_drop_cnt;
   logic [15:0]             r_filt_cnt;

   // Candidate evaluation
   logic [BW-1:0]                w_cand_blk [3];
   logic [2:0]                   w_cand_v;
   logic [2:0][QUEUE_DEPTH-1:0]  w_q_hit;
   logic [2:0][FILTER_DEPTH-1:0] w_f_hit;
   logic                         w_pop;
   logic [CW-1:0]                w_free;
   logic [2:0]                   w_en;
   logic [PW-1:0]                w_idx [3];
   logic [1:0]                   w_push_n;
   logic [1:0]                   w_dup_n;
   logic [1:0]                   w_drop_n;
   logic                         w_unused_lsb;

   assign w_cand_blk[0] = bus.pref_addr1_i[63:6];
   assign w_cand_blk[1] = bus.pref_addr2_i[63:6];
   assign w_cand_blk[2] = bus.pref_addr3_i[63:6];
   assign w_cand_v      = {bus.pref_valid3_i, bus.pref_valid2_i, bus.pref_valid1_i};
   assign w_unused_lsb  = ^{bus.pref_addr1_i[5:0], bus.pref_addr2_i[5:0], bus.pref_addr3_i[5:0]};

   assign w_pop  = (r_count != '0) && bus.issue_ready_i;
   // A pop this cycle frees its slot for this cycle's candidates.
   assign w_free = CW'(QUEUE_DEPTH) - r_count + CW'(w_pop);

   // The popping head keeps its valid bit until the edge, so it still
   // participates in duplicate detection this cycle.
   for (genvar gk = 0; gk < 3; gk++) begin : g_cand
      for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_qcmp
         assign w_q_hit[gk][gi] = r_q_valid[gi] && (r_q_blk[gi] == w_cand_blk[gk]);
      end
      for (genvar gi = 0; gi < FILTER_DEPTH; gi++) begin : g_fcmp
         assign w_f_hit[gk][gi] = r_f_valid[gi] && (r_f_blk[gi] == w_cand_blk[gk]);
      end
   end

   // Candidates are resolved in order 1,2,3; each enqueued candidate takes
   // the next write slot after the ones granted before it.
   always_comb begin
      logic [1:0] push;
      logic [1:0] dup;
      logic [1:0] drop;
      logic       is_dup;
      push   = '0;
      dup    = '0;
      drop   = '0;
      is_dup = 1'b0;
      w_en   = '0;
      for (int k = 0; k < 3; k++) begin
         w_idx[k] = r_wr_ptr + PW'(push);
         is_dup   = (|w_q_hit[k]) || (|w_f_hit[k]);
         for (int j = 0; j < k; j++) begin
            if (w_en[j] && (w_cand_blk[j] == w_cand_blk[k])) begin
               is_dup = 1'b1;
            end
         end
         if (w_cand_v[k]) begin
            if (is_dup) begin
               dup = dup + 2'd1;
            end else if (CW'(push) < w_free) begin
               w_en[k] = 1'b1;
               push    = push + 2'd1;
            end else begin
               drop = drop + 2'd1;
            end
         end
      end
      w_push_n = push;
      w_dup_n  = dup;
      w_drop_n = drop;
   end

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] n);
      logic [16:0] s;
      s = {1'b0, a} + {15'b0, n};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q_valid  <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_f_valid  <= '0;
         r_f_ptr    <= '0;
         r_drop_cnt <= '0;
         r_filt_cnt <= '0;
      end else begin
         if (w_pop) begin
            r_q_valid[r_rd_ptr] <= 1'b0;
            r_rd_ptr            <= r_rd_ptr + PW'(1);
            r_f_blk[r_f_ptr]    <= r_q_blk[r_rd_ptr];
            r_f_valid[r_f_ptr]  <= 1'b1;
            r_f_ptr             <= (r_f_ptr == FW'(FILTER_DEPTH - 1)) ? '0 : r_f_ptr + FW'(1);
         end
         // Placed after the pop clear: when full with a pop, the new entry
         // lands in the freed head slot and must end up valid.
         for (int k = 0; k < 3; k++) begin
            if (w_en[k]) begin
               r_q_blk[w_idx[k]]   <= w_cand_blk[k];
               r_q_valid[w_idx[k]] <= 1'b1;
            end
         end
         r_wr_ptr   <= r_wr_ptr + PW'(w_push_n);
         r_count    <= r_count + CW'(w_push_n) - CW'(w_pop);
         r_drop_cnt <= sat_add(r_drop_cnt, w_drop_n);
         r_filt_cnt <= sat_add(r_filt_cnt, w_dup_n);
      end
   end

   assign bus.issue_valid_o  = (r_count != '0);
   assign bus.issue_addr_o   = (r_count != '0) ? {r_q_blk[r_rd_ptr], 6'b0} : 64'd0;
   assign bus.count_o        = r_count;
   assign bus.drop_count_o   = r_drop_cnt;
   assign bus.filter_count_o = r_filt_cnt;
endmodule

// File: tb/tb_pref_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_pref_issue_queue
// Purpose : directed test of pref_issue_queue (QUEUE_DEPTH=8, FILTER_DEPTH=8).
//           Expected issue addresses are queued when candidates are driven
//           and compared whenever the queue pops its head.
// ---------------------------------------------------------------------------
module tb_pref_issue_queue;
   logic clk;
   logic rst;

   int vectors;
   int miscompares;
   logic [63:0] sb[$];

   pref_issue_queue_if #(.QUEUE_DEPTH(8)) bus();

   pref_issue_queue #(
      .QUEUE_DEPTH  (8),
      .FILTER_DEPTH (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Compare any pop against the scoreboard, then advance one clock.
   task automatic tick();
      logic [63:0] exp;
      if (rst && bus.issue_valid_o && bus.issue_ready_i) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL unexpected_issue: observed 0x%0h expected none", bus.issue_addr_o);
         end else begin
            exp = sb.pop_front();
            chk("issue_addr", bus.issue_addr_o, exp);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cand(input logic v1, input logic [63:0] a1,
                       input logic v2, input logic [63:0] a2,
                       input logic v3, input logic [63:0] a3);
      bus.pref_valid1_i = v1; bus.pref_addr1_i = a1;
      bus.pref_valid2_i = v2; bus.pref_addr2_i = a2;
      bus.pref_valid3_i = v3; bus.pref_addr3_i = a3;
   endtask

   task automatic no_cand();
      cand(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0);
   endtask

   initial begin
      logic [63:0] a;
      vectors     = 0;
      miscompares = 0;
      rst = 1'b0;
      bus.issue_ready_i = 1'b0;
      no_cand();

      // Reset state
      repeat (2) tick();
      chk("rst_count", bus.count_o, 0);
      chk("rst_valid", bus.issue_valid_o, 0);
      chk("rst_addr", bus.issue_addr_o, 0);
      chk("rst_drop", bus.drop_count_o, 0);
      chk("rst_filt", bus.filter_count_o, 0);
      rst = 1'b1;
      tick();

      // Three candidates issue in order on consecutive cycles
      bus.issue_ready_i = 1'b1;
      cand(1'b1, 64'h1000, 1'b1, 64'h1040, 1'b1, 64'h1080);
      sb.push_back(64'h1000); sb.push_back(64'h1040); sb.push_back(64'h1080);
      tick();
      no_cand();
      chk("seq_count3", bus.count_o, 3);
      chk("seq_head", bus.issue_addr_o, 64'h1000);
      tick(); chk("seq_count2", bus.count_o, 2);
      tick(); chk("seq_count1", bus.count_o, 1);
      tick(); chk("seq_count0", bus.count_o, 0);
      chk("seq_valid0", bus.issue_valid_o, 0);

      // Same-cycle duplicates on block address
      bus.issue_ready_i = 1'b0;
      cand(1'b1, 64'h2000, 1'b1, 64'h2010, 1'b1, 64'h2000);
      sb.push_back(64'h2000);
      tick();
      no_cand();
      chk("dup_count", bus.count_o, 1);
      chk("dup_filt", bus.filter_count_o, 2);
      chk("dup_addr", bus.issue_addr_o, 64'h2000);
      bus.issue_ready_i = 1'b1;
      tick();
      chk("dup_drain", bus.count_o, 0);

      // Fill with ready low: ninth candidate is lost
      bus.issue_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cand(1'b1, 64'h10000 + 64'((3*c+0)*64),
              1'b1, 64'h10000 + 64'((3*c+1)*64),
              1'b1, 64'h10000 + 64'((3*c+2)*64));
         for (int k = 0; k < 3; k++) begin
            if (3*c + k < 8) sb.push_back(64'h10000 + 64'((3*c+k)*64));
         end
         tick();
      end
      no_cand();
      chk("full_count", bus.count_o, 8);
      chk("full_drop", bus.drop_count_o, 1);
      chk("full_head_stable", bus.issue_addr_o, 64'h10000);

      // Full queue: pop frees a slot for a same-cycle candidate
      bus.issue_ready_i = 1'b1;
      cand(1'b1, 64'h20000, 1'b0, 64'd0, 1'b0, 64'd0);
      sb.push_back(64'h20000);
      tick();
      no_cand();
      chk("popfill_count", bus.count_o, 8);
      chk("popfill_drop", bus.drop_count_o, 1);
      repeat (8) tick();
      chk("drain_count", bus.count_o, 0);

      // Recently issued address is filtered
      cand(1'b1, 64'h20000, 1'b0, 64'd0, 1'b0, 64'd0);
      tick();
      no_cand();
      chk("recent_filt", bus.filter_count_o, 3);
      chk("recent_count", bus.count_o, 0);

      // Filter ageing: 0x3000 filtered, then accepted after 8 newer pops
      cand(1'b1, 64'h3000, 1'b0, 64'd0, 1'b0, 64'd0);
      sb.push_back(64'h3000);
      tick();
      no_cand();
      chk("age_first_count", bus.count_o, 1);
      tick();
      cand(1'b1, 64'h3000, 1'b0, 64'd0, 1'b0, 64'd0);
      tick();
      no_cand();
      chk("age_filtered", bus.filter_count_o, 4);
      chk("age_filtered_count", bus.count_o, 0);
      for (int i = 0; i < 8; i++) begin
         a = 64'h40000 + 64'(i*64);
         cand(1'b1, a, 1'b0, 64'd0, 1'b0, 64'd0);
         sb.push_back(a);
         tick();
      end
      no_cand();
      tick();
      cand(1'b1, 64'h3000, 1'b0, 64'd0, 1'b0, 64'd0);
      sb.push_back(64'h3000);
      tick();
      no_cand();
      chk("age_reaccept_count", bus.count_o, 1);
      chk("age_reaccept_filt", bus.filter_count_o, 4);
      chk("age_reaccept_addr", bus.issue_addr_o, 64'h3000);
      tick();
      chk("age_drain", bus.count_o, 0);

      // Mid-operation reset discards entries and ignores inputs
      bus.issue_ready_i = 1'b0;
      cand(1'b1, 64'h50000, 1'b1, 64'h50040, 1'b1, 64'h50080);
      tick();
      cand(1'b1, 64'h500C0, 1'b1, 64'h50100, 1'b0, 64'd0);
      tick();
      chk("pre_rst_count", bus.count_o, 5);
      rst = 1'b0;
      bus.issue_ready_i = 1'b1;
      cand(1'b1, 64'h60000, 1'b1, 64'h60040, 1'b1, 64'h60080);
      tick();
      chk("midrst_count", bus.count_o, 0);
      chk("midrst_valid", bus.issue_valid_o, 0);
      chk("midrst_addr", bus.issue_addr_o, 0);
      chk("midrst_drop", bus.drop_count_o, 0);
      chk("midrst_filt", bus.filter_count_o, 0);
      rst = 1'b1;
      no_cand();
      tick();
      chk("post_rst_count", bus.count_o, 0);
      // Filter was cleared, so an earlier-issued address is accepted
      cand(1'b1, 64'h1000, 1'b0, 64'd0, 1'b0, 64'd0);
      sb.push_back(64'h1000);
      tick();
      no_cand();
      chk("post_rst_accept", bus.count_o, 1);
      tick();
      chk("post_rst_drain", bus.count_o, 0);

      // Drop counter saturation
      bus.issue_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cand(1'b1, 64'h70000 + 64'((3*c+0)*64),
              1'b1, 64'h70000 + 64'((3*c+1)*64),
              1'b1, 64'h70000 + 64'((3*c+2)*64));
         tick();
      end
      chk("sat_fill_count", bus.count_o, 8);
      chk("sat_fill_drop", bus.drop_count_o, 1);
      // Identical candidates: none enqueued, so none counts as duplicate
      cand(1'b1, 64'h90000, 1'b1, 64'h90000, 1'b1, 64'h90000);
      repeat (21844) tick();
      chk("sat_pre", bus.drop_count_o, 65533);
      chk("sat_no_dup", bus.filter_count_o, 0);
      tick();
      chk("sat_hit", bus.drop_count_o, 16'hFFFF);
      tick();
      chk("sat_hold", bus.drop_count_o, 16'hFFFF);

      // Final reset discards the full queue without issue
      rst = 1'b0;
      no_cand();
      tick();
      rst = 1'b1;
      tick();
      chk("final_count", bus.count_o, 0);
      chk("sb_empty", 64'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
